// File: rtl/comp_pkg.sv
// Shared definitions for the sequential complex divider: state encoding, datapath widths,
// derived output width and divider step count. COMP_DIV_ROUND_EN adds one rounding quotient bit.
package comp_pkg;

    localparam int IN_W      = 8;
    localparam int PROD_W    = 16;
    localparam int ACC_W     = 17;
    localparam int MUL_STEPS = 6;

`ifdef COMP_DIV_ROUND_EN
    localparam int RND_BITS = 1;
`else
    localparam int RND_BITS = 0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV_R = 2'd2,
        DIV_I = 2'd3
    } state_t;

    function automatic int out_width(input int frac);
        return 9 + frac;
    endfunction

    function automatic int div_steps(input int frac);
        return ACC_W + frac + RND_BITS;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Bit-serial restoring unsigned divider: one quotient bit per cycle, MSB first, DW cycles per division.
// The final quotient and done are presented combinationally during the last step.
module seq_udiv #(
    parameter int DW = 23,
    parameter int VW = 17,
    parameter int QW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic          done,
    output logic          running
);

    localparam int CW = $clog2(DW);

    logic [VW-1:0] rem_reg, rem_cur, rem_next;
    logic [DW-1:0] dvd_reg, dvd_cur;
    logic [VW-1:0] dsr_reg, dsr_cur;
    logic [QW-2:0] quot_reg, quot_cur;
    logic [CW-1:0] cnt_reg, cnt_cur;
    logic          run_reg, active, take;
    logic [VW:0]   trial;

    // A start step works straight from the inputs so no load cycle is spent.
    always_comb begin
        active   = start | run_reg;
        rem_cur  = start ? '0 : rem_reg;
        dvd_cur  = start ? dividend : dvd_reg;
        dsr_cur  = start ? divisor : dsr_reg;
        quot_cur = start ? '0 : quot_reg;
        cnt_cur  = start ? '0 : cnt_reg;
        trial    = {rem_cur, dvd_cur[DW-1]};
        take     = (trial >= {1'b0, dsr_cur});
        rem_next = take ? VW'(trial - {1'b0, dsr_cur}) : trial[VW-1:0];
        quotient = {quot_cur, take};
        done     = active && (cnt_cur == CW'(DW - 1));
    end

    assign running = run_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_reg  <= '0;
            dvd_reg  <= '0;
            dsr_reg  <= '0;
            quot_reg <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
        end else if (active) begin
            rem_reg  <= rem_next;
            dvd_reg  <= {dvd_cur[DW-2:0], 1'b0};
            dsr_reg  <= dsr_cur;
            quot_reg <= quotient[QW-2:0];
            cnt_reg  <= cnt_cur + CW'(1);
            run_reg  <= ~done;
        end
    end

endmodule

// File: rtl/comp_div_one.sv
// Sequential complex divider q = a / b: a*conj(b) and |b|^2 via one shared 8x8 multiplier,
// then one shared bit-serial divider per component. COMP_DIV_ROUND_EN selects round-half-away.
module comp_div_one
    import comp_pkg::*;
#(
    parameter  int FRAC = 6,
    localparam int OW   = out_width(FRAC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] a_r,
    input  logic signed [IN_W-1:0] a_i,
    input  logic signed [IN_W-1:0] b_r,
    input  logic signed [IN_W-1:0] b_i,
    input  logic                   i_en,
    output logic signed [OW-1:0]   q_r,
    output logic signed [OW-1:0]   q_i,
    output logic                   o_en,
    output logic                   o_dz,
    output logic                   busy
);

    localparam int N  = div_steps(FRAC);
    localparam int SH = N - ACC_W;
    localparam int QW = OW + RND_BITS;

    state_t state_reg, state_next;

    logic [2:0]               step_reg;
    logic signed [IN_W-1:0]   ar_reg, ai_reg, br_reg, bi_reg;
    logic signed [IN_W-1:0]   mul_x, mul_y;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  num_r_reg, num_i_reg, num_sel;
    logic [ACC_W-1:0]         den_reg, num_mag;
    logic signed [OW-1:0]     qr_hold_reg, q_r_reg, q_i_reg;
    logic                     o_en_reg, o_dz_reg, busy_reg;
    logic                     capture, mul_en, div_start, keep_r, fin;
    logic [N-1:0]             div_dividend;
    logic [QW-1:0]            div_quot;
    logic                     div_done, div_running;

    function automatic logic signed [OW-1:0] apply_sign(input logic [QW-1:0] qt, input logic neg);
        logic [OW-1:0] m;
`ifdef COMP_DIV_ROUND_EN
        m = OW'(({1'b0, qt} + (QW + 1)'(1)) >> 1);
`else
        m = qt;
`endif
        return neg ? -$signed(m) : $signed(m);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (i_en) state_next = MUL;
            MUL:   if (step_reg == 3'(MUL_STEPS - 1)) state_next = DIV_R;
            DIV_R: if (div_done) state_next = DIV_I;
            DIV_I: if (div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture   = (state_reg == IDLE) && i_en;
        mul_en    = (state_reg == MUL);
        div_start = ((state_reg == DIV_R) || (state_reg == DIV_I)) && !div_running;
        keep_r    = (state_reg == DIV_R) && div_done;
        fin       = (state_reg == DIV_I) && div_done;
    end

    // Product order: a_r*b_r, a_i*b_i, a_i*b_r, a_r*b_i, b_r*b_r, b_i*b_i.
    always_comb begin
        mul_x = ar_reg;
        mul_y = br_reg;
        case (step_reg)
            3'd1: begin mul_x = ai_reg; mul_y = bi_reg; end
            3'd2: begin mul_x = ai_reg; mul_y = br_reg; end
            3'd3: begin mul_x = ar_reg; mul_y = bi_reg; end
            3'd4: begin mul_x = br_reg; mul_y = br_reg; end
            3'd5: begin mul_x = bi_reg; mul_y = bi_reg; end
            default: ;
        endcase
        prod = mul_x * mul_y;
    end

    always_comb begin
        num_sel      = (state_reg == DIV_I) ? num_i_reg : num_r_reg;
        num_mag      = num_sel[ACC_W-1] ? ACC_W'(-num_sel) : ACC_W'(num_sel);
        div_dividend = N'(num_mag) << SH;
    end

    seq_udiv #(
        .DW(N),
        .VW(ACC_W),
        .QW(QW)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (den_reg),
        .quotient(div_quot),
        .done    (div_done),
        .running (div_running)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_reg    <= '0;
            ar_reg      <= '0;
            ai_reg      <= '0;
            br_reg      <= '0;
            bi_reg      <= '0;
            num_r_reg   <= '0;
            num_i_reg   <= '0;
            den_reg     <= '0;
            qr_hold_reg <= '0;
            q_r_reg     <= '0;
            q_i_reg     <= '0;
            o_en_reg    <= 1'b0;
            o_dz_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            o_en_reg <= 1'b0;
            if (capture) begin
                ar_reg   <= a_r;
                ai_reg   <= a_i;
                br_reg   <= b_r;
                bi_reg   <= b_i;
                step_reg <= '0;
                busy_reg <= 1'b1;
            end
            if (mul_en) begin
                step_reg <= step_reg + 3'd1;
                case (step_reg)
                    3'd0: num_r_reg <= ACC_W'(prod);
                    3'd1: num_r_reg <= num_r_reg + ACC_W'(prod);
                    3'd2: num_i_reg <= ACC_W'(prod);
                    3'd3: num_i_reg <= num_i_reg - ACC_W'(prod);
                    3'd4: den_reg   <= ACC_W'(prod);
                    3'd5: den_reg   <= den_reg + ACC_W'(prod);
                    default: ;
                endcase
            end
            if (keep_r) qr_hold_reg <= apply_sign(div_quot, num_r_reg[ACC_W-1]);
            // A zero denominator still runs full length; its meaningless quotient is dropped here.
            if (fin) begin
                q_r_reg  <= (den_reg == '0) ? '0 : qr_hold_reg;
                q_i_reg  <= (den_reg == '0) ? '0 : apply_sign(div_quot, num_i_reg[ACC_W-1]);
                o_dz_reg <= (den_reg == '0);
                o_en_reg <= 1'b1;
                busy_reg <= 1'b0;
            end
        end
    end

    assign q_r  = q_r_reg;
    assign q_i  = q_i_reg;
    assign o_en = o_en_reg;
    assign o_dz = o_dz_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_comp_div_one.sv
// Scoreboard bench for comp_div_one: directed vectors push expected results, a monitor pops on o_en.
module tb_comp_div_one;

    localparam int FRAC = 6;
    localparam int OW   = 9 + FRAC;
`ifdef COMP_DIV_ROUND_EN
    localparam int LAT = 8 + 2 * (17 + FRAC);
`else
    localparam int LAT = 6 + 2 * (17 + FRAC);
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [7:0]    a_r = '0, a_i = '0, b_r = '0, b_i = '0;
    logic                 i_en = 1'b0;
    logic signed [OW-1:0] q_r, q_i;
    logic                 o_en, o_dz, busy;

    typedef struct {
        int qr;
        int qi;
        int dz;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   prev_oen = 1'b0;

    comp_div_one #(.FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .a_r (a_r),
        .a_i (a_i),
        .b_r (b_r),
        .b_i (b_i),
        .i_en(i_en),
        .q_r (q_r),
        .q_i (q_i),
        .o_en(o_en),
        .o_dz(o_dz),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per o_en pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_oen) chk("o_en_one_cycle", int'(o_en), 0);
            if (o_en) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_o_en actual 1 required 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("q_r", int'(q_r), mon_e.qr);
                    chk("q_i", int'(q_i), mon_e.qi);
                    chk("o_dz", int'(o_dz), mon_e.dz);
                    chk("latency_cycle", cyc, mon_e.cyc);
                    chk("busy_low_at_o_en", int'(busy), 0);
                    $display("txn cycle %0d q_r %0d q_i %0d o_dz %0d (req %0d %0d %0d)",
                             cyc, q_r, q_i, o_dz, mon_e.qr, mon_e.qi, mon_e.dz);
                end
            end
            prev_oen = o_en;
        end else begin
            prev_oen = 1'b0;
        end
    end

    // Called at a negedge; drives i_en for exactly one rising edge.
    task automatic issue(input int ar, input int ai, input int br, input int bi,
                         input int eqr, input int eqi, input int edz, input bit track);
        a_r  = 8'(ar);
        a_i  = 8'(ai);
        b_r  = 8'(br);
        b_i  = 8'(bi);
        i_en = 1'b1;
        if (track) sbq.push_back('{eqr, eqi, edz, cyc + 1 + LAT});
        @(negedge clk);
        i_en = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_idle(input int exp_n);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual busy=1 required busy=0 (cycle %0d)", cyc);
        end else if (exp_n >= 0) begin
            chk("busy_cycles", n, exp_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_q_r", int'(q_r), 0);
        chk("reset_q_i", int'(q_i), 0);
        chk("reset_o_en", int'(o_en), 0);
        chk("reset_o_dz", int'(o_dz), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        issue(10, 0, 2, 0, 320, 0, 0, 1'b1);
        wait_idle(LAT);
`ifdef COMP_DIV_ROUND_EN
        issue(3, 4, 1, 2, 141, -26, 0, 1'b1);
`else
        issue(3, 4, 1, 2, 140, -25, 0, 1'b1);
`endif
        wait_idle(LAT);
        issue(-128, -128, 1, -1, 0, -8192, 0, 1'b1);
        wait_idle(LAT);
        issue(5, -7, 0, 0, 0, 0, 1, 1'b1);
        wait_idle(LAT);
`ifdef COMP_DIV_ROUND_EN
        issue(-7, 3, 2, 1, -141, 166, 0, 1'b1);
`else
        issue(-7, 3, 2, 1, -140, 166, 0, 1'b1);
`endif
        wait_idle(LAT);
        issue(-128, -128, -128, -128, 64, 0, 0, 1'b1);
        wait_idle(LAT);

        // A second start while busy must be ignored.
        issue(-128, -128, 1, 0, -8192, -8192, 0, 1'b1);
        repeat (9) @(negedge clk);
        a_r  = 8'sd1;
        a_i  = 8'sd1;
        b_r  = 8'sd1;
        b_i  = 8'sd1;
        i_en = 1'b1;
        @(negedge clk);
        i_en = 1'b0;
        chk("busy_during_ignored_start", int'(busy), 1);
        wait_idle(LAT - 10);
        issue(127, 0, 1, 0, 8128, 0, 0, 1'b1);
        wait_idle(LAT);

        // Abort in the middle of DIV_R.
        issue(3, 4, 1, 2, 0, 0, 0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_q_r", int'(q_r), 0);
        chk("abort_q_i", int'(q_i), 0);
        chk("abort_o_en", int'(o_en), 0);
        chk("abort_o_dz", int'(o_dz), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);

        issue(10, 0, 2, 0, 320, 0, 0, 1'b1);
        wait_idle(LAT);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
